// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing FSM state type and default 640x480@60 timing.
package vga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CNT_W    = 11;
   localparam int unsigned DEF_FRAME_W  = 16;

   function automatic int unsigned seg_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter with registered sync and look-ahead active decode.
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter bit          POL    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             live,
   output logic [CNT_W-1:0] cnt,
   output logic             sync,
   output logic             last_c,
   output logic             active_nxt_c
);

   localparam int unsigned TOTAL   = seg_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned SYNC_LO = ACTIVE + FP;
   localparam int unsigned SYNC_HI = ACTIVE + FP + SYNC;
   localparam int unsigned EXT_W   = CNT_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] cnt_nxt;
   logic [EXT_W-1:0] cnt_ext;
   logic             sync_on_c;

   // Decode from the next count so registered flags line up with the registered count
   always_comb begin
      last_c  = (cnt == LAST);
      cnt_nxt = cnt;
      if (step) begin
         cnt_nxt = last_c ? '0 : cnt + CNT_W'(1);
      end
      cnt_ext      = {1'b0, cnt_nxt};
      active_nxt_c = (cnt_ext < EXT_W'(ACTIVE));
      sync_on_c    = live && (cnt_ext >= EXT_W'(SYNC_LO)) && (cnt_ext < EXT_W'(SYNC_HI));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= LAST;
         sync <= ~POL;
      end else begin
         cnt  <= cnt_nxt;
         sync <= sync_on_c ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: run/drain/idle control over per-axis counters; whole frames only.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
   input  logic               PCLK_I,
   input  logic               RST_I,
   input  logic               CE_I,
   input  logic               EN_I,
   output logic               DE_O,
   output logic               HSYNC_O,
   output logic               VSYNC_O,
   output logic [CNT_W-1:0]   HCNT_O,
   output logic [CNT_W-1:0]   VCNT_O,
   output logic               SOL_O,
   output logic               SOF_O,
   output logic [FRAME_W-1:0] FRAME_O,
   output logic               BUSY_O
);

   localparam int unsigned H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
   end
   if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
   end

   state_t state, state_nxt;
   logic   adv_c, frame_end_c, live_nxt_c;
   logic   h_last, v_last, h_act_nxt, v_act_nxt;

   vga_axis_cnt #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W), .POL(H_POL)
   ) u_h_axis (
      .clk          (PCLK_I),
      .rst          (RST_I),
      .step         (adv_c),
      .live         (live_nxt_c),
      .cnt          (HCNT_O),
      .sync         (HSYNC_O),
      .last_c       (h_last),
      .active_nxt_c (h_act_nxt)
   );

   vga_axis_cnt #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W), .POL(V_POL)
   ) u_v_axis (
      .clk          (PCLK_I),
      .rst          (RST_I),
      .step         (adv_c & h_last),
      .live         (live_nxt_c),
      .cnt          (VCNT_O),
      .sync         (VSYNC_O),
      .last_c       (v_last),
      .active_nxt_c (v_act_nxt)
   );

   // Parked counters sit on the last position, so leaving IDLE is an ordinary wrap to (0,0)
   always_comb begin
      state_nxt   = state;
      adv_c       = 1'b0;
      frame_end_c = h_last & v_last;
      if (CE_I) begin
         unique case (state)
            ST_IDLE: begin
               if (EN_I) begin
                  state_nxt = ST_RUN;
                  adv_c     = 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (frame_end_c && !EN_I) begin
                  state_nxt = ST_IDLE;
               end else begin
                  adv_c     = 1'b1;
                  state_nxt = EN_I ? ST_RUN : ST_DRAIN;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
      live_nxt_c = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge PCLK_I or posedge RST_I) begin
      if (RST_I) begin
         state   <= ST_IDLE;
         DE_O    <= 1'b0;
         SOL_O   <= 1'b0;
         SOF_O   <= 1'b0;
         FRAME_O <= '0;
         BUSY_O  <= 1'b0;
      end else begin
         state  <= state_nxt;
         DE_O   <= h_act_nxt & v_act_nxt & live_nxt_c;
         SOL_O  <= adv_c & h_last;
         SOF_O  <= adv_c & frame_end_c;
         BUSY_O <= live_nxt_c;
         if (adv_c && frame_end_c) begin
            FRAME_O <= FRAME_O + FRAME_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench: a small 14x7 instance for FSM behaviour, a default instance for line timing.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s, ce_s, en_s, rst_d, ce_d, en_d;
   logic        de_s, hs_s, vs_s, sol_s, sof_s, busy_s;
   logic        de_d, hs_d, vs_d, sol_d, sof_d, busy_d;
   logic [10:0] hc_s, vc_s, hc_d, vc_d;
   logic [15:0] fr_s, fr_d;

   int checks = 0;
   int errors = 0;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .CNT_W(11), .FRAME_W(16)
   ) u_small (
      .PCLK_I(clk), .RST_I(rst_s), .CE_I(ce_s), .EN_I(en_s),
      .DE_O(de_s), .HSYNC_O(hs_s), .VSYNC_O(vs_s), .HCNT_O(hc_s), .VCNT_O(vc_s),
      .SOL_O(sol_s), .SOF_O(sof_s), .FRAME_O(fr_s), .BUSY_O(busy_s)
   );

   vga_timing_gen u_dflt (
      .PCLK_I(clk), .RST_I(rst_d), .CE_I(ce_d), .EN_I(en_d),
      .DE_O(de_d), .HSYNC_O(hs_d), .VSYNC_O(vs_d), .HCNT_O(hc_d), .VCNT_O(vc_d),
      .SOL_O(sol_d), .SOF_O(sof_d), .FRAME_O(fr_d), .BUSY_O(busy_d)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Small instance status word: {busy, de, hsync, vsync, sol, sof}
   function automatic logic [31:0] st_s();
      return {26'd0, busy_s, de_s, hs_s, vs_s, sol_s, sof_s};
   endfunction

   initial begin
      int h, v, eh, nsol;
      logic [31:0] exp_v;

      rst_s = 1'b1; ce_s = 1'b0; en_s = 1'b0;
      rst_d = 1'b1; ce_d = 1'b0; en_d = 1'b0;
      #2;

      // Reset values before any clock edge
      chk("rst_s_hcnt", 32'(hc_s), 13);
      chk("rst_s_vcnt", 32'(vc_s), 6);
      chk("rst_s_status", st_s(), 32'h00);
      chk("rst_s_frame", 32'(fr_s), 0);
      chk("rst_d_hcnt", 32'(hc_d), 799);
      chk("rst_d_vcnt", 32'(vc_d), 524);
      chk("rst_d_status", {26'd0, busy_d, de_d, hs_d, vs_d, sol_d, sof_d}, 32'b001100);

      rst_s = 1'b0; ce_s = 1'b1; en_s = 1'b1;

      // First frame of the small instance, every pixel
      for (int k = 0; k < 98; k++) begin
         if (k > 0) tick(); else tick();
         h = k % 14;
         v = k / 14;
         exp_v = {5'd0, 11'(h), 11'(v), (h < 8 && v < 4), (h >= 10 && h < 12), (v == 5),
                  (h == 0), (h == 0 && v == 0)};
         chk($sformatf("s_frame1_k%0d", k),
             {5'd0, hc_s, vc_s, de_s, hs_s, vs_s, sol_s, sof_s}, exp_v);
      end
      chk("s_frame1_cnt", 32'(fr_s), 1);
      tick();
      chk("s_period98_h", 32'(hc_s), 0);
      chk("s_period98_v", 32'(vc_s), 0);
      chk("s_period98_status", st_s(), 32'b110011);
      chk("s_period98_frame", 32'(fr_s), 2);

      // CE_I=0 holds everything; pulses drop
      ce_s = 1'b0;
      tick();
      chk("s_hold_h", 32'(hc_s), 0);
      chk("s_hold_v", 32'(vc_s), 0);
      chk("s_hold_status", st_s(), 32'b110000);
      chk("s_hold_frame", 32'(fr_s), 2);
      tick();
      chk("s_hold2_h", 32'(hc_s), 0);
      ce_s = 1'b1;

      // Stop: drop EN_I on line 1, frame completes then IDLE
      ticks(14);
      chk("s_line1_v", 32'(vc_s), 1);
      en_s = 1'b0;
      tick();
      chk("s_drain_h", 32'(hc_s), 1);
      chk("s_drain_status", st_s(), 32'b110000);
      ticks(82);
      chk("s_drain_end_h", 32'(hc_s), 13);
      chk("s_drain_end_v", 32'(vc_s), 6);
      chk("s_drain_end_busy", 32'(busy_s), 1);
      tick();
      chk("s_idle_h", 32'(hc_s), 13);
      chk("s_idle_v", 32'(vc_s), 6);
      chk("s_idle_status", st_s(), 32'h00);
      chk("s_idle_frame", 32'(fr_s), 2);
      ticks(3);
      chk("s_idle3_h", 32'(hc_s), 13);
      chk("s_idle3_frame", 32'(fr_s), 2);

      // Restart from IDLE
      en_s = 1'b1;
      tick();
      chk("s_restart_h", 32'(hc_s), 0);
      chk("s_restart_v", 32'(vc_s), 0);
      chk("s_restart_status", st_s(), 32'b110011);
      chk("s_restart_frame", 32'(fr_s), 3);

      // EN_I low on lines 2..4 then back high: no gap before next frame
      ticks(28);
      en_s = 1'b0;
      ticks(28);
      chk("s_drain2_v", 32'(vc_s), 4);
      chk("s_drain2_busy", 32'(busy_s), 1);
      en_s = 1'b1;
      ticks(41);
      chk("s_b2b_pre_h", 32'(hc_s), 13);
      chk("s_b2b_pre_v", 32'(vc_s), 6);
      tick();
      chk("s_b2b_h", 32'(hc_s), 0);
      chk("s_b2b_v", 32'(vc_s), 0);
      chk("s_b2b_sof", 32'(sof_s), 1);
      chk("s_b2b_frame", 32'(fr_s), 4);

      // Mid-frame reset at (10,5) where both syncs are asserted
      ticks(80);
      chk("s_pre_rst_h", 32'(hc_s), 10);
      chk("s_pre_rst_status", st_s(), 32'b101100);
      #2;
      rst_s = 1'b1;
      #1;
      chk("s_mrst_h", 32'(hc_s), 13);
      chk("s_mrst_v", 32'(vc_s), 6);
      chk("s_mrst_status", st_s(), 32'h00);
      chk("s_mrst_frame", 32'(fr_s), 0);
      tick();
      chk("s_mrst_held_h", 32'(hc_s), 13);
      rst_s = 1'b0;
      tick();
      chk("s_after_rst_h", 32'(hc_s), 0);
      chk("s_after_rst_status", st_s(), 32'b110011);
      chk("s_after_rst_frame", 32'(fr_s), 1);
      ce_s = 1'b0;

      // Default 640x480 instance: two full lines
      rst_d = 1'b0; ce_d = 1'b1; en_d = 1'b1;
      tick();
      chk("d_first_sof", {28'd0, busy_d, sof_d, sol_d, de_d}, 32'b1111);
      chk("d_first_frame", 32'(fr_d), 1);
      for (int k = 0; k < 1600; k++) begin
         if (k > 0) tick();
         h = k % 800;
         v = k / 800;
         exp_v = {6'd0, 11'(h), 11'(v), (h < 640), !(h >= 656 && h < 752), 1'b1, (h == 0)};
         chk($sformatf("d_line_k%0d", k), {6'd0, hc_d, vc_d, de_d, hs_d, vs_d, sol_d}, exp_v);
      end
      tick();
      chk("d_line2_h", 32'(hc_d), 0);
      chk("d_line2_v", 32'(vc_d), 2);
      chk("d_line2_sol", 32'(sol_d), 1);

      // CE_I toggling: one advance every other clock, 1600-cycle line
      eh = 0;
      nsol = 0;
      for (int i = 0; i < 1600; i++) begin
         ce_d = (i % 2 == 1);
         tick();
         if (ce_d) eh = (eh == 799) ? 0 : eh + 1;
         chk($sformatf("d_ce_i%0d", i), {9'd0, hc_d, vc_d, de_d},
             {9'd0, 11'(eh), 11'((i == 1599) ? 3 : 2), (eh < 640)});
         chk($sformatf("d_ce_sol_i%0d", i), 32'(sol_d), 32'(ce_d && eh == 0));
         nsol += int'(sol_d);
      end
      chk("d_ce_sol_count", 32'(nsol), 1);
      chk("d_ce_frame", 32'(fr_d), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
